score_bin2bcd_seq: RTL and testbench

//  Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) for on-screen

---
 rtl/score_bin2bcd_seq_if.sv | 34 +++
 rtl/score_bin2bcd_seq.sv | 167 ++++++++++++++++
 tb/tb_score_bin2bcd_seq.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_bin2bcd_seq_if.sv
// Handshake bundle for the iterative binary-to-BCD converter.
// Master drives start/bin_in; slave returns status and result.
interface score_bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  ovf,
    input  blank
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output ovf,
    output blank
  );
endinterface

// File: rtl/score_bin2bcd_seq.sv
// Iterative shift-and-add-3 binary to BCD converter, one bit per clock.
// Optional leading-zero mask enabled by macro BCD_BLANK_EN.
module score_bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  score_bin2bcd_seq_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int AW = BW + 4;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last_bit;
  logic [BIN_W-1:0] sh_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_adj;
  logic [AW-1:0]    acc_nx;
  logic [CW-1:0]    cnt_q;
  logic             ovf_pend_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_nx;
  logic             ovf_q;

  assign last_bit = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and accept strobe; start honoured in IDLE and DONE only
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Add 3 to every nibble >= 5 (guard nibble included) before the shift
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i <= DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Carry out of the guard nibble is dropped; ovf covers that range
  assign acc_nx = AW'({acc_adj, sh_q[BIN_W-1]});
  assign bcd_nx = ovf_pend_q ? {DIGITS{4'h9}} : acc_nx[BW-1:0];

  // Working registers: load on accept, shift one bit per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else if (accept) begin
      sh_q       <= bus.bin_in;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= (64'(bus.bin_in) >= LIMIT);
    end else if (state_q == SHIFT) begin
      sh_q       <= sh_q << 1;
      acc_q      <= acc_nx;
      cnt_q      <= cnt_q + CW'(1);
    end
  end

  // Result registers updated on the final shift, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if ((state_q == SHIFT) && last_bit) begin
      bcd_q <= bcd_nx;
      ovf_q <= ovf_pend_q;
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;

  function automatic logic [DIGITS-1:0] lead_zero(input logic [BW-1:0] v);
    logic              z;
    logic [DIGITS-1:0] m;
    z = 1'b1;
    m = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (v[4*i +: 4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction

  // Leading-zero mask registered alongside the result; digit 0 always shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if ((state_q == SHIFT) && last_bit) begin
      blank_q <= ovf_pend_q ? '0 : lead_zero(bcd_nx);
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_score_bin2bcd_seq.sv
// Testbench for score_bin2bcd_seq across four parameter sets.
// Table vectors, handshake corner sequences and a random sweep.
module tb_score_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

`ifdef BCD_BLANK_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif

  score_bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5))  i0 ();
  score_bin2bcd_seq_if #(.BIN_W(16), .DIGITS(4))  i1 ();
  score_bin2bcd_seq_if #(.BIN_W(10), .DIGITS(4))  i2 ();
  score_bin2bcd_seq_if #(.BIN_W(32), .DIGITS(10)) i3 ();

  score_bin2bcd_seq #(.BIN_W(16), .DIGITS(5))  d0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  score_bin2bcd_seq #(.BIN_W(16), .DIGITS(4))  d1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  score_bin2bcd_seq #(.BIN_W(10), .DIGITS(4))  d2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  score_bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) d3 (.clk(clk), .rst_n(rst_n), .bus(i3));

  int checks = 0;
  int failures = 0;

  int bw_of [4] = '{16, 16, 10, 32};
  int dg_of [4] = '{5, 4, 4, 10};

  typedef struct {
    int          sel;
    logic [31:0] v;
    logic [39:0] bcd;
    logic        ovf;
    logic [9:0]  blk;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [31:0] v);
    case (sel)
      0: begin i0.start = s; i0.bin_in = v[15:0]; end
      1: begin i1.start = s; i1.bin_in = v[15:0]; end
      2: begin i2.start = s; i2.bin_in = v[9:0]; end
      default: begin i3.start = s; i3.bin_in = v; end
    endcase
  endtask

  task automatic peek(input int sel, output logic dn, output logic bz,
                      output logic [39:0] b, output logic o,
                      output logic [9:0] bl);
    case (sel)
      0: begin
        dn = i0.done; bz = i0.busy; b = 40'(i0.bcd_out);
        o = i0.ovf; bl = 10'(i0.blank);
      end
      1: begin
        dn = i1.done; bz = i1.busy; b = 40'(i1.bcd_out);
        o = i1.ovf; bl = 10'(i1.blank);
      end
      2: begin
        dn = i2.done; bz = i2.busy; b = 40'(i2.bcd_out);
        o = i2.ovf; bl = 10'(i2.blank);
      end
      default: begin
        dn = i3.done; bz = i3.busy; b = 40'(i3.bcd_out);
        o = i3.ovf; bl = 10'(i3.blank);
      end
    endcase
  endtask

  // lat counts edges from the accepting edge (1) to the one raising done
  task automatic conv(input int sel, input logic [31:0] v,
                      output logic [39:0] b, output logic o,
                      output logic [9:0] bl, output int lat,
                      output int bcnt);
    logic dn;
    logic bz;
    drive(sel, 1'b1, v);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, v);
    lat = 1;
    bcnt = 0;
    peek(sel, dn, bz, b, o, bl);
    while (!dn && lat < 100) begin
      if (bz) bcnt++;
      @(posedge clk);
      #1;
      lat++;
      peek(sel, dn, bz, b, o, bl);
    end
  endtask

  function automatic logic [63:0] p10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [39:0] mdl_bcd(input logic [63:0] v, input int d);
    logic [39:0] r;
    logic [63:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      if (v >= p10(d)) r[4*i +: 4] = 4'h9;
      else r[4*i +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [9:0] mdl_blk(input logic [39:0] b, input int d,
                                         input logic o);
    logic [9:0] r;
    logic z;
    r = '0;
    z = 1'b1;
    if (BLK_EN && !o) begin
      for (int i = d - 1; i >= 1; i--) begin
        z = z & (b[4*i +: 4] == 4'd0);
        r[i] = z;
      end
    end
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] b;
    logic        o;
    logic [9:0]  bl;
    logic        dn;
    logic        bz;
    int          lat;
    int          bcnt;
    int          n;
    int          t;
    int          t1;
    logic [31:0] v;
    logic [31:0] msk;

    tbl[0]  = '{0, 32'd2048,       40'h02048,      1'b0, 10'b10000};
    tbl[1]  = '{0, 32'd65535,      40'h65535,      1'b0, 10'b00000};
    tbl[2]  = '{0, 32'd0,          40'h00000,      1'b0, 10'b11110};
    tbl[3]  = '{0, 32'd7,          40'h00007,      1'b0, 10'b11110};
    tbl[4]  = '{0, 32'd10000,      40'h10000,      1'b0, 10'b00000};
    tbl[5]  = '{0, 32'd99,         40'h00099,      1'b0, 10'b11100};
    tbl[6]  = '{1, 32'd12345,      40'h9999,       1'b1, 10'b0000};
    tbl[7]  = '{1, 32'd9999,       40'h9999,       1'b0, 10'b0000};
    tbl[8]  = '{1, 32'd10000,      40'h9999,       1'b1, 10'b0000};
    tbl[9]  = '{1, 32'd42,         40'h0042,       1'b0, 10'b1100};
    tbl[10] = '{2, 32'd1023,       40'h1023,       1'b0, 10'b0000};
    tbl[11] = '{2, 32'd5,          40'h0005,       1'b0, 10'b1110};
    tbl[12] = '{3, 32'd4294967295, 40'h4294967295, 1'b0, 10'b0};
    tbl[13] = '{3, 32'd1000000,    40'h0001000000, 1'b0, 10'b1110000000};

    for (int s = 0; s < 4; s++) drive(s, 1'b0, 32'd0);

    // asynchronous reset, outputs checked while still held
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    peek(0, dn, bz, b, o, bl);
    chk("rst_busy", 64'(bz), 64'd0);
    chk("rst_done", 64'(dn), 64'd0);
    chk("rst_bcd", 64'(b), 64'd0);
    chk("rst_ovf", 64'(o), 64'd0);
    chk("rst_blank", 64'(bl), 64'd0);
    peek(3, dn, bz, b, o, bl);
    chk("rst_bcd3", 64'(b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven vectors
    for (int k = 0; k < 14; k++) begin
      conv(tbl[k].sel, tbl[k].v, b, o, bl, lat, bcnt);
      chk($sformatf("tbl%0d_bcd", k), 64'(b), 64'(tbl[k].bcd));
      chk($sformatf("tbl%0d_ovf", k), 64'(o), 64'(tbl[k].ovf));
      chk($sformatf("tbl%0d_blank", k), 64'(bl),
          64'(BLK_EN ? tbl[k].blk : 10'd0));
      chk($sformatf("tbl%0d_lat", k), 64'(lat), 64'(bw_of[tbl[k].sel] + 1));
      chk($sformatf("tbl%0d_busy", k), 64'(bcnt), 64'(bw_of[tbl[k].sel]));
    end

    // back-to-back with start held through DONE
    drive(0, 1'b1, 32'd65535);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 32'd0);
    t = 1;
    n = 0;
    t1 = 0;
    while (n < 2 && t < 100) begin
      peek(0, dn, bz, b, o, bl);
      if (dn) begin
        n++;
        if (n == 1) begin
          chk("b2b_first", 64'(b), 64'h65535);
          t1 = t;
        end else begin
          chk("b2b_second", 64'(b), 64'h0);
          chk("b2b_gap", 64'(t - t1), 64'd17);
          chk("b2b_blank", 64'(bl), 64'(BLK_EN ? 10'b11110 : 10'd0));
          drive(0, 1'b0, 32'd0);
        end
      end
      if (n < 2) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    chk("b2b_count", 64'(n), 64'd2);
    drive(0, 1'b0, 32'd0);
    @(posedge clk);
    #1;

    // start while busy is ignored
    drive(0, 1'b1, 32'd1234);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd1234);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    drive(0, 1'b1, 32'd999);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd0);
    peek(0, dn, bz, b, o, bl);
    chk("ign_busy", 64'(bz), 64'd1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      peek(0, dn, bz, b, o, bl);
      if (dn) n++;
      @(posedge clk);
      #1;
    end
    peek(0, dn, bz, b, o, bl);
    chk("ign_done_cnt", 64'(n), 64'd1);
    chk("ign_bcd", 64'(b), 64'h01234);

    // reset mid-conversion
    drive(0, 1'b1, 32'd4096);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    peek(0, dn, bz, b, o, bl);
    chk("mrst_busy", 64'(bz), 64'd0);
    chk("mrst_done", 64'(dn), 64'd0);
    chk("mrst_bcd", 64'(b), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 25; c++) begin
      peek(0, dn, bz, b, o, bl);
      if (dn || bz) n++;
      @(posedge clk);
      #1;
    end
    chk("mrst_quiet", 64'(n), 64'd0);
    conv(0, 32'd4096, b, o, bl, lat, bcnt);
    chk("mrst_bcd_after", 64'(b), 64'h04096);
    chk("mrst_lat_after", 64'(lat), 64'd17);

    // random sweep against the decimal reference model
    for (int s = 1; s < 4; s++) begin
      msk = (bw_of[s] == 32) ? 32'hFFFF_FFFF : ((32'd1 << bw_of[s]) - 32'd1);
      for (int k = 0; k < 30; k++) begin
        v = $urandom & msk;
        conv(s, v, b, o, bl, lat, bcnt);
        chk($sformatf("rnd%0d_%0d_bcd", s, k), 64'(b),
            64'(mdl_bcd(64'(v), dg_of[s])));
        chk($sformatf("rnd%0d_%0d_ovf", s, k), 64'(o),
            64'(64'(v) >= p10(dg_of[s])));
        chk($sformatf("rnd%0d_%0d_blank", s, k), 64'(bl),
            64'(mdl_blk(mdl_bcd(64'(v), dg_of[s]), dg_of[s],
                        64'(v) >= p10(dg_of[s]))));
        chk($sformatf("rnd%0d_%0d_lat", s, k), 64'(lat), 64'(bw_of[s] + 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
